// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: length-prefixed byte stream into instruction memory, then CPU release
// Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_FINISH, S_RUN, S_ERR
    } state_t;
    localparam state_t S_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_FINISH, S_RUN, S_ERR
    } state_t;
    localparam state_t S_END = S_FINISH;
`endif

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hold_q, hold_d;
    logic [15:0]         idx_q, idx_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic [15:0]         len_new;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    assign accept  = in_valid && in_ready_q;
    assign len_new = {len_q[15:8], in_data};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        if (accept && (state_q == S_DATA_HI || state_q == S_DATA_LO))
            sum_d = sum_q + in_data;
`endif
        case (state_q)
            S_LEN_HI: if (accept) begin
                len_d[15:8] = in_data;
                state_d     = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d = len_new;
                if (32'(len_new) > DEPTH) state_d = S_ERR;
                else if (len_new == 16'd0) state_d = S_END;
                else state_d = S_DATA_HI;
            end
            S_DATA_HI: if (accept) begin
                hold_d  = in_data;
                state_d = S_DATA_LO;
            end
            S_DATA_LO: if (accept) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = {hold_q, in_data};
                mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                idx_d       = idx_q + 16'd1;
                state_d     = (idx_q == len_q - 16'd1) ? S_END : S_DATA_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: if (accept) begin
                state_d = (in_data == sum_q) ? S_FINISH : S_ERR;
            end
`endif
            S_FINISH: state_d = S_RUN;
            S_RUN, S_ERR: if (reload) begin
                state_d = S_LEN_HI;
                idx_d   = 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d   = 8'd0;
`endif
            end
            default: state_d = S_LEN_HI;
        endcase
        // Status outputs track the next state so they line up with state_q after the edge.
        in_ready_d = (state_d != S_RUN) && (state_d != S_ERR) && (state_d != S_FINISH);
        cpu_rst_d  = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'd0;
            hold_q      <= 8'd0;
            idx_q       <= 16'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'd0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
// Honours PROG_LOADER_CHECKSUM_EN by appending checksum bytes to every image.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    bit          have_we = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] exp_e;
    logic [31:0] exp_q[$];
    logic [15:0] img[$];

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every pulse is popped against the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            check("we_cpu_rst", 32'(cpu_rst), 32'd1);
            if (exp_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
            else begin
                exp_e = exp_q.pop_front();
                check("we_addr", 32'(mem_addr), 32'(exp_e[25:16]));
                check("we_data", 32'(mem_wdata), 32'(exp_e[15:0]));
            end
            last_we_cyc = cyc;
            have_we = 1'b1;
        end
        if (!cpu_rst && prev_rst && have_we) begin
            check("release_lat", 32'(cyc - last_we_cyc), 32'd1);
            have_we = 1'b0;
        end
        if (reload) have_we = 1'b0;
        prev_rst = cpu_rst;
    end

    task automatic send_byte(input logic [7:0] b, input int gmax);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        repeat ($urandom_range(gmax, 0)) @(negedge clk);
    endtask

    task automatic load(input int gmax);
        logic [7:0] sum;
        int         n;
        sum = 8'd0;
        n = img.size();
        send_byte(8'(n >> 8), gmax);
        send_byte(8'(n), gmax);
        foreach (img[i]) begin
            send_byte(img[i][15:8], gmax);
            exp_q.push_back({6'd0, 10'(i), img[i]});
            sum = sum + img[i][15:8] + img[i][7:0];
            send_byte(img[i][7:0], gmax);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(sum, gmax);
`endif
    endtask

    task automatic wait_end(input logic exp_err);
        int n;
        n = 0;
        while (!done && !error && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 32'(done || error), 32'd1);
        check("done", 32'(done), 32'(!exp_err));
        check("error", 32'(error), 32'(exp_err));
        check("cpu_rst", 32'(cpu_rst), 32'(exp_err));
        check("in_ready_idle", 32'(in_ready), 32'd0);
        check("missing_we", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("rl_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rl_done", 32'(done), 32'd0);
        check("rl_error", 32'(error), 32'd0);
        check("rl_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        img = '{16'h1234, 16'hABCD};
        load(0);
        wait_end(1'b0);

        do_reload();
        img.delete();
        load(0);
        wait_end(1'b0);

        do_reload();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        wait_end(1'b1);
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("err_not_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        do_reload();
        img = '{16'h0102, 16'hFEED, 16'h8000};
        load(0);
        wait_end(1'b0);
        do_reload();
        load(5);
        wait_end(1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({6'd0, 10'd0, 16'h0005});
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        wait_end(1'b1);
`endif

        // Reset after one and a half words; the coinciding byte must be dropped.
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        exp_q.push_back({6'd0, 10'd0, 16'h1234});
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        in_data = 8'h78;
        in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_writes", 32'(exp_q.size()), 32'd0);

        img = '{16'hBEEF};
        load(0);
        wait_end(1'b0);
        do_reload();
        img = '{16'hCAFE};
        load(2);
        wait_end(1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
